// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers one payload, then emits header, payload and
// parity bytes to the router with busy back-pressure.
module router_pkt_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       dest_addr,
   input  logic [5:0]       pay_len,
   input  logic             inject_err,
   input  logic [WIDTH-1:0] pay_data,
   input  logic             pay_valid,
   output logic             pay_ready,
   input  logic             busy,
   output logic             pkt_valid,
   output logic [WIDTH-1:0] data_out,
   output logic             tx_idle,
   output logic             done
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_HEADER  = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
   localparam logic [2:0] S_PARITY  = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]       state;
   logic [5:0]       len_q;
   logic [1:0]       addr_q;
   logic             inject_q;
   logic [5:0]       count;
   logic [5:0]       index;
   logic [WIDTH-1:0] parity;
   logic [WIDTH-1:0] buffer [0:62];

   assign pay_ready = (state == S_LOAD);
   assign tx_idle   = (state == S_IDLE);

   // NOTE: the payload buffer has no reset; every entry read is written first
   // in LOAD, so resetting it would only add reset fan-out to a RAM.
   always_ff @(posedge clock) begin
      if (state == S_LOAD && pay_valid)
         buffer[count] <= pay_data;
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // sees the pre-edge value of every other register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         len_q     <= '0;
         addr_q    <= '0;
         inject_q  <= 1'b0;
         count     <= '0;
         index     <= '0;
         parity    <= '0;
         data_out  <= '0;
         pkt_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && pay_len != 6'd0 && dest_addr != 2'd3) begin
                  len_q    <= pay_len;
                  addr_q   <= dest_addr;
                  inject_q <= inject_err;
                  count    <= '0;
                  parity   <= {pay_len, dest_addr};
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (pay_valid) begin
                  count  <= count + 6'd1;
                  parity <= parity ^ pay_data;
                  if (count == len_q - 6'd1) begin
                     data_out  <= {len_q, addr_q};
                     pkt_valid <= 1'b1;
                     state     <= S_HEADER;
                  end
               end
            end
            S_HEADER: begin
               if (!busy) begin
                  data_out <= buffer[0];
                  index    <= 6'd1;
                  state    <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (!busy) begin
                  if (index < len_q) begin
                     data_out <= buffer[index];
                     index    <= index + 6'd1;
                  end else begin
                     // Parity goes out with pkt_valid low to mark end of packet.
                     data_out  <= parity ^ {{(WIDTH-1){1'b0}}, inject_q};
                     pkt_valid <= 1'b0;
                     state     <= S_PARITY;
                  end
               end
            end
            S_PARITY: begin
               if (!busy) begin
                  data_out <= '0;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus pushes expected bytes, a
// negedge monitor pops and compares every byte the router consumes.
module tb_router_pkt_tx;

   localparam logic [1:0] K_BYTE = 2'd0;
   localparam logic [1:0] K_PAR  = 2'd1;
   localparam logic [1:0] K_DONE = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] dest_addr;
   logic [5:0] pay_len;
   logic       inject_err;
   logic [7:0] pay_data;
   logic       pay_valid;
   logic       pay_ready;
   logic       busy;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       tx_idle;
   logic       done;

   exp_t       exp_q[$];
   logic [7:0] pay_buf [0:62];
   int         tests = 0;
   int         fails = 0;

   router_pkt_tx #(.WIDTH(8)) dut (
      .clock(clock), .reset(reset), .start(start), .dest_addr(dest_addr),
      .pay_len(pay_len), .inject_err(inject_err), .pay_data(pay_data),
      .pay_valid(pay_valid), .pay_ready(pay_ready), .busy(busy),
      .pkt_valid(pkt_valid), .data_out(data_out), .tx_idle(tx_idle), .done(done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic pop_and_check(input logic [1:0] kind, input logic [7:0] data);
      exp_t e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_output: kind %0d data 0x%0h with nothing expected at %0t",
                  kind, data, $time);
      end else begin
         e = exp_q.pop_front();
         check("out_kind", {30'd0, kind}, {30'd0, e.kind});
         if (e.kind != K_DONE) check("out_data", {24'd0, data}, {24'd0, e.data});
      end
   endtask

   // Monitor: a byte is consumed when presented with busy low at the next edge.
   initial begin
      logic       prev_valid = 1'b0;
      logic       prev_busy  = 1'b0;
      logic [7:0] prev_data  = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_valid = 1'b0;
            prev_busy  = 1'b0;
         end else begin
            if (prev_valid && prev_busy) begin
               check("hold_valid", {31'd0, pkt_valid}, 32'd1);
               check("hold_data", {24'd0, data_out}, {24'd0, prev_data});
            end
            if (pkt_valid && !busy)
               pop_and_check(K_BYTE, data_out);
            else if (!pkt_valid && prev_valid)
               pop_and_check(K_PAR, data_out);
            if (done)
               pop_and_check(K_DONE, 8'h00);
            prev_valid = pkt_valid;
            prev_busy  = busy;
            prev_data  = data_out;
         end
      end
   end

   task automatic push_expect(input logic [7:0] hdr, input int len, input logic [7:0] par);
      exp_q.push_back('{kind: K_BYTE, data: hdr});
      for (int i = 0; i < len; i++) exp_q.push_back('{kind: K_BYTE, data: pay_buf[i]});
      exp_q.push_back('{kind: K_PAR, data: par});
      exp_q.push_back('{kind: K_DONE, data: 8'h00});
   endtask

   // Issues start now, then feeds the payload; junk on the sampled-with-start
   // inputs during LOAD must not disturb the packet.
   task automatic start_and_load(input logic [1:0] a, input logic [5:0] l,
                                 input logic inj, input bit toggle);
      int sent = 0;
      int cyc  = 0;
      bit ph   = 1'b0;
      start = 1'b1; dest_addr = a; pay_len = l; inject_err = inj;
      @(posedge clock); #1;
      check("start_taken", {31'd0, tx_idle}, 32'd0);
      dest_addr = 2'd3; pay_len = 6'd0; inject_err = ~inj;
      while (sent < int'(l) && cyc < 300) begin
         if (toggle && ph) begin
            pay_valid = 1'b0; pay_data = 8'hA5;
         end else begin
            pay_valid = 1'b1; pay_data = pay_buf[sent];
         end
         ph = ~ph;
         #3;
         if (pay_valid && pay_ready) sent++;
         @(posedge clock); #1;
         cyc++;
      end
      start = 1'b0; pay_valid = 1'b0;
      check("load_count", sent, {26'd0, l});
      check("load_ready_low", {31'd0, pay_ready}, 32'd0);
   endtask

   task automatic wait_drain();
      int c = 0;
      while (exp_q.size() != 0 && c < 400) begin
         @(posedge clock); #1;
         c++;
      end
      check("drain_left", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) begin @(posedge clock); #1; end
   endtask

   task automatic set_short();
      pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      reset = 1'b1; start = 1'b0; dest_addr = '0; pay_len = '0; inject_err = 1'b0;
      pay_data = '0; pay_valid = 1'b0; busy = 1'b0;
      #1;
      check("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
      check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pay_ready", {31'd0, pay_ready}, 32'd0);
      @(posedge clock); #2;
      reset = 1'b0;

      // Basic packet to address 1, three bytes.
      set_short();
      push_expect(8'h0D, 3, 8'h0D);
      start_and_load(2'd1, 6'd3, 1'b0, 1'b0);
      wait_drain();

      // Same packet with parity error injected.
      push_expect(8'h0D, 3, 8'h0C);
      start_and_load(2'd1, 6'd3, 1'b1, 1'b0);
      wait_drain();

      // Router stalls two cycles while 0x22 is presented.
      push_expect(8'h0D, 3, 8'h0D);
      start_and_load(2'd1, 6'd3, 1'b0, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (pkt_valid && data_out == 8'h22) begin
            found = 1'b1;
            busy  = 1'b1;
            repeat (2) begin @(posedge clock); #1; end
            busy = 1'b0;
         end else begin
            @(posedge clock); #1;
         end
      end
      check("stall_hit", {31'd0, found}, 32'd1);
      wait_drain();

      // Illegal requests: zero length, then address 3.
      pay_valid = 1'b1; pay_data = 8'h5A;
      start = 1'b1; dest_addr = 2'd1; pay_len = 6'd0;
      repeat (3) begin
         @(posedge clock); #1;
         check("len0_idle", {31'd0, tx_idle}, 32'd1);
         check("len0_ready", {31'd0, pay_ready}, 32'd0);
         check("len0_valid", {31'd0, pkt_valid}, 32'd0);
      end
      dest_addr = 2'd3; pay_len = 6'd5;
      repeat (3) begin
         @(posedge clock); #1;
         check("addr3_idle", {31'd0, tx_idle}, 32'd1);
         check("addr3_ready", {31'd0, pay_ready}, 32'd0);
         check("addr3_valid", {31'd0, pkt_valid}, 32'd0);
      end
      start = 1'b0; pay_valid = 1'b0;

      // Full 63-byte packet to address 2 with pay_valid toggling.
      for (int i = 0; i < 63; i++) pay_buf[i] = 8'(i + 1);
      push_expect(8'hFE, 63, 8'hFE);
      start_and_load(2'd2, 6'd63, 1'b0, 1'b1);
      wait_drain();

      // Asynchronous reset mid-payload, then a clean packet straight after.
      set_short();
      push_expect(8'h0D, 3, 8'h0D);
      start_and_load(2'd1, 6'd3, 1'b0, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (pkt_valid && data_out == 8'h22) found = 1'b1;
         else begin @(posedge clock); #1; end
      end
      check("abort_reached_payload", {31'd0, found}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("abort_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      check("abort_data_out", {24'd0, data_out}, 32'd0);
      check("abort_tx_idle", {31'd0, tx_idle}, 32'd1);
      exp_q.delete();
      @(posedge clock); #2;
      reset = 1'b0;
      push_expect(8'h0D, 3, 8'h0D);
      start_and_load(2'd1, 6'd3, 1'b0, 1'b0);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
